// File: rtl/rv_pkg.sv
// Shared RV32I encoding definitions.
// Instruction class codes and base opcodes.
package rv_pkg;

  typedef enum logic [3:0] {
    CLS_LOAD   = 4'd0,
    CLS_STORE  = 4'd1,
    CLS_RTYPE  = 4'd2,
    CLS_BRANCH = 4'd3,
    CLS_ITYPE  = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_SYSTEM = 4'd9
  } cls_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } enc_st_e;

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packer.
// Builds the 32-bit word and flags illegal class/immediate.
module imm_pack
  import rv_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic shift;
  assign shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (cls)
      CLS_LOAD:
        word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      CLS_STORE:
        word = {imm[11:5], rs2, rs1, funct3,
                imm[4:0], OP_STORE};
      CLS_RTYPE:
        word = {1'b0, funct7b5, 5'b0, rs2, rs1,
                funct3, rd, OP_RTYPE};
      CLS_BRANCH: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3,
                imm[4:1], imm[11], OP_BRANCH};
        illegal = imm[0];
      end
      CLS_ITYPE: begin
        // shifts carry shamt in imm[4:0]; srai sets bit 30
        if (shift)
          word = {1'b0, funct3[2] & funct7b5, 5'b0,
                  imm[4:0], rs1, funct3, rd, OP_ITYPE};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_ITYPE};
      end
      CLS_JAL: begin
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], rd, OP_JAL};
        illegal = imm[0];
      end
      CLS_JALR:
        word = {imm[11:0], rs1, funct3, rd, OP_JALR};
      CLS_LUI:
        word = {imm[31:12], rd, OP_LUI};
      CLS_AUIPC:
        word = {imm[31:12], rd, OP_AUIPC};
      CLS_SYSTEM:
        word = {imm[11:0], rs1, funct3, rd, OP_SYSTEM};
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_enc.sv
// Instruction encoder: packs fields and writes words
// sequentially into IMEM via a held-until-ack write.
module instr_enc
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cls,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ack,
  output logic [15:0] count,
  output logic        err
);

  enc_st_e     st, st_nx;
  logic [31:0] addr_nx, wdata_nx;
  logic [15:0] count_nx;
  logic        err_nx;
  logic [31:0] word;
  logic        illegal;

  imm_pack u_pack (
    .cls      (in_cls),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .word     (word),
    .illegal  (illegal)
  );

  assign in_ready = (st == ST_IDLE);
  assign imem_we  = (st == ST_WRITE);

  always_comb begin
    st_nx    = st;
    addr_nx  = imem_addr;
    wdata_nx = imem_wdata;
    count_nx = count;
    err_nx   = err;
    if (start) begin
      st_nx    = ST_IDLE;
      addr_nx  = base_addr;
      count_nx = '0;
      err_nx   = 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (in_valid) begin
            if (illegal) begin
              err_nx = 1'b1;
            end else begin
              wdata_nx = word;
              st_nx    = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            addr_nx = imem_addr + 32'd4;
            if (count != 16'hFFFF)
              count_nx = count + 16'd1;
            st_nx = ST_IDLE;
          end
        end
        default: st_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      st         <= st_nx;
      imem_addr  <= addr_nx;
      imem_wdata <= wdata_nx;
      count      <= count_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: pulse; loads the write pointer from base_addr and clears count.
REQ-004 SHALL have port base_addr, input, 32 bits: first IMEM byte address, word-aligned.
REQ-005 SHALL have port in_valid, input, 1 bit: instruction fields valid.
REQ-006 SHALL have port in_ready, output, 1 bit: encoder can accept fields.
REQ-007 SHALL have port in_cls, input, 4 bits: instruction class, one of LOAD, STORE, RTYPE, BRANCH, ITYPE, JAL, JALR, LUI, AUIPC, SYSTEM.
REQ-008 SHALL have ports in_funct3 (input, 3 bits) and in_funct7b5 (input, 1 bit).
REQ-009 SHALL have ports in_rd, in_rs1 and in_rs2, each input, 5 bits.
REQ-010 SHALL have port in_imm, input, 32 bits: sign-extended immediate; for LUI/AUIPC it is the full value with bits [11:0] ignored.
REQ-011 SHALL have ports imem_we (output, 1 bit), imem_addr (output, 32 bits) and imem_wdata (output, 32 bits).
REQ-012 SHALL have port imem_ack, input, 1 bit: IMEM accepted the write this cycle.
REQ-013 SHALL have ports count (output, 16 bits, words written) and err (output, 1 bit, sticky).

Function
REQ-014 SHALL implement FSM states IDLE and WRITE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL, on in_valid&&in_ready with a legal class, register the encoded word into imem_wdata and enter WRITE next cycle (1-cycle latency).
REQ-017 SHALL, in WRITE, hold imem_we=1 with imem_addr and imem_wdata stable until imem_ack.
REQ-018 SHALL, on imem_ack in WRITE, advance imem_addr by 4 (mod 2^32), increment count (saturating at 0xFFFF) and return to IDLE.
REQ-019 SHALL apply opcodes LOAD 0000011, STORE 0100011, RTYPE 0110011, BRANCH 1100011, ITYPE 0010011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
REQ-020 SHALL place immediate bits per RV32I formats: I for LOAD/ITYPE/JALR/SYSTEM; S for STORE; B using imm[12:1]; U using imm[31:12]; J using imm[20:1].
REQ-021 SHALL set bit30 = in_funct7b5 for RTYPE, and for ITYPE when funct3=101; ITYPE shifts use imm[4:0] as shamt.
REQ-022 SHALL zero every field unused by the format (e.g. rs2 in I-type, rd in S/B).
REQ-023 SHALL, for an undefined in_cls or for BRANCH/JAL with in_imm[0]=1, consume the handshake, set err, stay in IDLE, and issue no write.
REQ-024 SHALL let start take priority over everything: abort any pending write (imem_we=0), return to IDLE, load imem_addr=base_addr, clear count and err.
REQ-025 SHALL make imem_ack outside WRITE no-effect.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, count=0 and err=0 immediately; reset mid-WRITE drops the word.

Structure
REQ-027 SHALL place class enum codes (LOAD=0 … SYSTEM=9) and the opcode localparams in the shared package rv_pkg, used by both the decoder and this block.
REQ-028 SHALL split out one combinational sub-module, imm_pack (class, fields → 32-bit word, illegal flag); instr_enc holds the FSM, pointer and counters.

Verification
REQ-029 ITYPE addi, rd=1, rs1=0, imm=5, start with base 0x100 → one write: addr 0x100, data 0x00500093; count=1.
REQ-030 STORE sw rs2=2, rs1=0, f3=010, imm=8 → data 0x00202423; BRANCH beq x0,x0, imm=-4 → data 0xFE000EE3.
REQ-031 JAL rd=1, imm=8 → data 0x008000EF; LUI rd=5, imm=0x12345000 → data 0x123452B7; addresses advance by 4.
REQ-032 imem_ack withheld 5 cycles → imem_we, addr and data stable and in_ready=0 throughout; exactly one count increment.
REQ-033 in_cls=15, then JAL with imm=3 → err=1, no imem_we, count unchanged; a following start clears err.
REQ-034 Base 0xFFFFFFFC with two writes → second write at address 0x00000000; rst_n low mid-WRITE → all outputs 0 asynchronously.
